age_allocator: RTL and testbench
================================

AGE_ALLOCATOR -- requirements
Module: age_allocator

Interface
REQ-001 The block SHALL have parameter ENTNUM, default 8, meaning the number of reservation-station entries.
REQ-002 The block SHALL have parameter ENTLEN, default 3, meaning the entry index width, equal to log2(ENTNUM).
REQ-003 The block SHALL have parameter VALLEN, default 8, meaning the age-tag width.
REQ-004 Port clk_i  input  1  clock; the block SHALL use one clock, all state on its rising edge.
REQ-005 Port rst_n_i  input  1  reset; the block SHALL treat it as asynchronous and active-low.
REQ-006 Port flush_i  input  1  pipeline flush.
REQ-007 Port alloc_valid_i  input  1  allocation request.
REQ-008 Port alloc_ready_o  output  1  block can accept an allocation this cycle.
REQ-009 Port alloc_entry_o  output  ENTLEN  entry granted to the current request.
REQ-010 Port alloc_age_o  output  VALLEN  age tag stamped on the granted entry.
REQ-011 Port free_valid_i  input  1  entry release (issue) strobe.
REQ-012 Port free_entry_i  input  ENTLEN  entry being released.
REQ-013 Port busy_vector_o  output  ENTNUM  per-entry busy bits.
REQ-014 Port age_vector_o  output  ENTNUM*VALLEN  per-entry ages, entry k at bits [k*VALLEN +: VALLEN], for the oldest-select tree.

Function
REQ-015 alloc_entry_o SHALL be the lowest-indexed non-busy entry (combinational); alloc_age_o SHALL equal the current age counter.
REQ-016 alloc_ready_o SHALL be 1 only when state==NORMAL, at least one entry is free, and counter != 2^VALLEN-1.
REQ-017 On alloc_valid_i & alloc_ready_o the block SHALL set busy[alloc_entry_o], store alloc_age_o in that entry, and increment the counter at the next edge (1-cycle latency).
REQ-018 alloc_valid_i without alloc_ready_o SHALL have no effect; the requester holds the request.
REQ-019 On free_valid_i the block SHALL clear busy[free_entry_i] at the next edge; freeing a non-busy entry SHALL be ignored.
REQ-020 When free and alloc occur in the same cycle, the block SHALL allocate from the pre-free busy vector, so a freed entry is not reusable until the next cycle.
REQ-021 Ages of non-busy entries SHALL be held unchanged and are don't-care to consumers.
REQ-022 FSM states: NORMAL, SATURATED. NORMAL->SATURATED when the counter reaches 2^VALLEN-1; SATURATED->NORMAL per REQ-027/028.
REQ-023 The counter SHALL never wrap; ordering by unsigned compare SHALL stay valid for all busy entries.
REQ-024 flush_i SHALL, at the next edge, clear all busy bits, zero the counter, and force NORMAL; flush SHALL take priority over same-cycle alloc and free.
REQ-025 alloc_ready_o SHALL be 0 in the flush cycle.

Reset
REQ-026 On rst_n_i low the block SHALL immediately set: busy all 0, ages all 0, counter 0, state NORMAL; alloc_ready_o SHALL then read 1, alloc_entry_o 0, alloc_age_o 0.

Configuration
REQ-027 Without macro AGE_REBASE_EN, SATURATED SHALL hold alloc_ready_o=0 until busy_vector_o is all zero; the block SHALL then zero the counter and return to NORMAL the next edge.
REQ-028 With AGE_REBASE_EN, in SATURATED each cycle the block SHALL compute m = min age over busy entries; if no entry is busy it SHALL zero the counter; if m>0 it SHALL subtract m from every busy age and the counter and return to NORMAL; if m==0 it SHALL stay in SATURATED and re-evaluate.
REQ-029 With AGE_REBASE_EN, a same-cycle free SHALL still be applied, with m taken from the pre-free vector.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (NORMAL, SATURATED) and the default ENTNUM/ENTLEN/VALLEN constants.
REQ-031 The lowest-free priority encoder SHALL be one sub-module, free_entry_encoder; the AGE_REBASE_EN minimum SHALL reuse the existing two-input oldest-select cell in a tree.

Verification (ENTNUM=4, VALLEN=3)
REQ-032 Reset, 4 back-to-back allocs -> entries 0,1,2,3 with ages 0,1,2,3; then alloc_ready_o=0 (full).
REQ-033 Full, free entry 2 plus same-cycle alloc -> no grant that cycle; next cycle grant entry 2, age 4.
REQ-034 Counter reaches 7 -> alloc_ready_o=0; without macro, free all -> counter 0 next edge, ready=1.
REQ-035 With AGE_REBASE_EN, busy ages {3,5,6}, counter 7 -> one cycle later ages {0,2,3}, counter 4, ready=1.
REQ-036 With AGE_REBASE_EN, busy age 0 present at counter 7 -> stays SATURATED until entry freed.
REQ-037 Flush with alloc and free asserted -> busy 0, counter 0, NORMAL next edge; rst_n_i low mid-SATURATED -> all outputs at reset values immediately.

Source files
------------

// File: rtl/age_allocator_pkg.sv
// Shared types and default sizing for the age allocator slice.
// Optional build macro used by this slice: AGE_REBASE_EN.
package age_allocator_pkg;

  localparam int DEF_ENTNUM = 8;
  localparam int DEF_ENTLEN = 3;
  localparam int DEF_VALLEN = 8;

  typedef enum logic [0:0] {
    NORMAL    = 1'b0,
    SATURATED = 1'b1
  } state_e;

endpackage

// File: rtl/free_entry_encoder.sv
// Lowest-index free-entry priority encoder over the busy vector.
module free_entry_encoder #(
  parameter int ENTNUM = 8,
  parameter int ENTLEN = 3
) (
  input  logic [ENTNUM-1:0] busy,
  output logic [ENTLEN-1:0] free_entry,
  output logic              free_found
);

  // Scan from the top so the lowest free index is the one left standing.
  always_comb begin
    free_entry = {ENTLEN{1'b0}};
    free_found = 1'b0;
    for (int k = ENTNUM - 1; k >= 0; k--) begin
      if (!busy[k]) begin
        free_entry = k[ENTLEN-1:0];
        free_found = 1'b1;
      end else begin
        free_found = free_found;
      end
    end
  end

endmodule

// File: rtl/oldest_select_cell.sv
// Two-input oldest-select cell (smallest valid age wins, ties to input a).
// Only built when AGE_REBASE_EN is defined, where it forms the minimum-age tree.
`ifdef AGE_REBASE_EN
module oldest_select_cell #(
  parameter int VALLEN = 8
) (
  input  logic              a_valid,
  input  logic [VALLEN-1:0] a_age,
  input  logic              b_valid,
  input  logic [VALLEN-1:0] b_age,
  output logic              y_valid,
  output logic [VALLEN-1:0] y_age
);

  // Pick the older of two candidates, ignoring invalid ones.
  always_comb begin
    y_valid = a_valid | b_valid;
    if (a_valid && (!b_valid || (a_age <= b_age))) begin
      y_age = a_age;
    end else begin
      y_age = b_age;
    end
  end

endmodule
`endif

// File: rtl/age_allocator.sv
// Reservation-station entry allocator stamping monotonically increasing age tags.
// Build macro AGE_REBASE_EN: rebase busy ages by their minimum instead of draining on saturation.
module age_allocator
  import age_allocator_pkg::*;
#(
  parameter int ENTNUM = DEF_ENTNUM,
  parameter int ENTLEN = DEF_ENTLEN,
  parameter int VALLEN = DEF_VALLEN
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     alloc_valid_i,
  output logic                     alloc_ready_o,
  output logic [ENTLEN-1:0]        alloc_entry_o,
  output logic [VALLEN-1:0]        alloc_age_o,
  input  logic                     free_valid_i,
  input  logic [ENTLEN-1:0]        free_entry_i,
  output logic [ENTNUM-1:0]        busy_vector_o,
  output logic [ENTNUM*VALLEN-1:0] age_vector_o
);

  localparam logic [VALLEN-1:0] CNT_MAX  = {VALLEN{1'b1}};
  localparam logic [VALLEN-1:0] CNT_ZERO = {VALLEN{1'b0}};
  localparam logic [VALLEN-1:0] CNT_ONE  = {{(VALLEN-1){1'b0}}, 1'b1};

  logic [ENTNUM-1:0] busy_r;
  logic [VALLEN-1:0] age_r [ENTNUM];
  logic [VALLEN-1:0] cnt_r;
  state_e            state_r;

  logic [ENTNUM-1:0] busy_nxt_s;
  logic [VALLEN-1:0] age_nxt_s [ENTNUM];
  logic [VALLEN-1:0] cnt_nxt_s;
  state_e            state_nxt_s;

  logic [ENTLEN-1:0] free_idx_s;
  logic              any_free_s;
  logic              ready_s;
  logic              fire_s;
  logic [VALLEN-1:0] cnt_inc_s;

  free_entry_encoder #(
    .ENTNUM(ENTNUM),
    .ENTLEN(ENTLEN)
  ) u_free_entry_encoder (
    .busy      (busy_r),
    .free_entry(free_idx_s),
    .free_found(any_free_s)
  );

  assign ready_s   = (state_r == NORMAL) && any_free_s && (cnt_r != CNT_MAX) && !flush_i;
  assign fire_s    = alloc_valid_i && ready_s;
  assign cnt_inc_s = cnt_r + CNT_ONE;

`ifdef AGE_REBASE_EN
  // Minimum busy age via a balanced tree of oldest-select cells; unused leaves are invalid.
  localparam int LEAVES = 1 << ENTLEN;
  logic              min_valid_s;
  logic [VALLEN-1:0] min_age_s;

  for (genvar l = 0; l <= ENTLEN; l++) begin : lvl_g
    localparam int W = LEAVES >> l;
    logic [W-1:0]        vld_s;
    logic [W*VALLEN-1:0] age_s;
    if (l == 0) begin : leaf_g
      for (genvar n = 0; n < W; n++) begin : leaf_n_g
        if (n < ENTNUM) begin : used_g
          assign vld_s[n]                 = busy_r[n];
          assign age_s[n*VALLEN +: VALLEN] = age_r[n];
        end else begin : pad_g
          assign vld_s[n]                 = 1'b0;
          assign age_s[n*VALLEN +: VALLEN] = CNT_ZERO;
        end
      end
    end else begin : node_g
      for (genvar n = 0; n < W; n++) begin : cell_g
        oldest_select_cell #(
          .VALLEN(VALLEN)
        ) u_cell (
          .a_valid(lvl_g[l-1].vld_s[2*n]),
          .a_age  (lvl_g[l-1].age_s[(2*n)*VALLEN +: VALLEN]),
          .b_valid(lvl_g[l-1].vld_s[2*n+1]),
          .b_age  (lvl_g[l-1].age_s[(2*n+1)*VALLEN +: VALLEN]),
          .y_valid(vld_s[n]),
          .y_age  (age_s[n*VALLEN +: VALLEN])
        );
      end
    end
  end

  assign min_valid_s = lvl_g[ENTLEN].vld_s[0];
  assign min_age_s   = lvl_g[ENTLEN].age_s[VALLEN-1:0];
`endif

  // Next-state: flush dominates, then free/alloc against the pre-free busy vector, then FSM.
  always_comb begin
    busy_nxt_s  = busy_r;
    cnt_nxt_s   = cnt_r;
    state_nxt_s = state_r;
    for (int k = 0; k < ENTNUM; k++) begin
      age_nxt_s[k] = age_r[k];
    end
    if (flush_i) begin
      busy_nxt_s  = {ENTNUM{1'b0}};
      cnt_nxt_s   = CNT_ZERO;
      state_nxt_s = NORMAL;
    end else begin
      if (free_valid_i) begin
        busy_nxt_s[free_entry_i] = 1'b0;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      if (fire_s) begin
        busy_nxt_s[free_idx_s] = 1'b1;
        age_nxt_s[free_idx_s]  = cnt_r;
        cnt_nxt_s              = cnt_inc_s;
      end else begin
        cnt_nxt_s = cnt_nxt_s;
      end
      case (state_r)
        NORMAL: begin
          if (fire_s && (cnt_inc_s == CNT_MAX)) begin
            state_nxt_s = SATURATED;
          end else begin
            state_nxt_s = NORMAL;
          end
        end
        SATURATED: begin
`ifdef AGE_REBASE_EN
          if (!min_valid_s) begin
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = NORMAL;
          end else if (min_age_s != CNT_ZERO) begin
            for (int k = 0; k < ENTNUM; k++) begin
              if (busy_r[k]) begin
                age_nxt_s[k] = age_r[k] - min_age_s;
              end else begin
                age_nxt_s[k] = age_r[k];
              end
            end
            cnt_nxt_s   = cnt_r - min_age_s;
            state_nxt_s = NORMAL;
          end else begin
            state_nxt_s = SATURATED;
          end
`else
          if (busy_r == {ENTNUM{1'b0}}) begin
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = NORMAL;
          end else begin
            state_nxt_s = SATURATED;
          end
`endif
        end
        default: begin
          state_nxt_s = NORMAL;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_r  <= {ENTNUM{1'b0}};
      cnt_r   <= CNT_ZERO;
      state_r <= NORMAL;
      for (int k = 0; k < ENTNUM; k++) begin
        age_r[k] <= CNT_ZERO;
      end
    end else begin
      busy_r  <= busy_nxt_s;
      cnt_r   <= cnt_nxt_s;
      state_r <= state_nxt_s;
      for (int k = 0; k < ENTNUM; k++) begin
        age_r[k] <= age_nxt_s[k];
      end
    end
  end

  assign alloc_ready_o = ready_s;
  assign alloc_entry_o = free_idx_s;
  assign alloc_age_o   = cnt_r;
  assign busy_vector_o = busy_r;

  for (genvar k = 0; k < ENTNUM; k++) begin : pack_g
    assign age_vector_o[k*VALLEN +: VALLEN] = age_r[k];
  end

endmodule

// File: tb/tb_age_allocator.sv
// Randomized self-checking bench for age_allocator (ENTNUM=4, VALLEN=3) against an array-based model.
// Follows AGE_REBASE_EN so the model matches whichever saturation policy is built.
module tb_age_allocator;

  localparam int ENTNUM = 4;
  localparam int ENTLEN = 2;
  localparam int VALLEN = 3;
  localparam int MAXCNT = 7;

  logic                     clk_i = 1'b0;
  logic                     rst_n_i;
  logic                     flush_i;
  logic                     alloc_valid_i;
  logic                     alloc_ready_o;
  logic [ENTLEN-1:0]        alloc_entry_o;
  logic [VALLEN-1:0]        alloc_age_o;
  logic                     free_valid_i;
  logic [ENTLEN-1:0]        free_entry_i;
  logic [ENTNUM-1:0]        busy_vector_o;
  logic [ENTNUM*VALLEN-1:0] age_vector_o;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_busy [ENTNUM];
  int m_age  [ENTNUM];
  int m_cnt;
  bit m_sat;

  age_allocator #(.ENTNUM(ENTNUM), .ENTLEN(ENTLEN), .VALLEN(VALLEN)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .flush_i      (flush_i),
    .alloc_valid_i(alloc_valid_i),
    .alloc_ready_o(alloc_ready_o),
    .alloc_entry_o(alloc_entry_o),
    .alloc_age_o  (alloc_age_o),
    .free_valid_i (free_valid_i),
    .free_entry_i (free_entry_i),
    .busy_vector_o(busy_vector_o),
    .age_vector_o (age_vector_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_lowest_free();
    for (int k = 0; k < ENTNUM; k++) if (!m_busy[k]) return k;
    return -1;
  endfunction

  function automatic bit model_ready(input bit fl);
    return !m_sat && (model_lowest_free() >= 0) && (m_cnt != MAXCNT) && !fl;
  endfunction

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v = 32'd0;
    for (int k = 0; k < ENTNUM; k++) v[k] = m_busy[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ENTNUM; k++) begin
      m_busy[k] = 1'b0;
      m_age[k]  = 0;
    end
    m_cnt = 0;
    m_sat = 1'b0;
  endtask

  task automatic model_step(input bit av, input bit fv, input int fe, input bit fl);
    bit pre [ENTNUM];
    bit fire;
    int e;
    int mn;
    if (fl) begin
      for (int k = 0; k < ENTNUM; k++) m_busy[k] = 1'b0;
      m_cnt = 0;
      m_sat = 1'b0;
      return;
    end
    for (int k = 0; k < ENTNUM; k++) pre[k] = m_busy[k];
    fire = av && model_ready(1'b0);
    e    = model_lowest_free();
    if (fv) m_busy[fe] = 1'b0;
    if (fire) begin
      m_busy[e] = 1'b1;
      m_age[e]  = m_cnt;
      m_cnt     = m_cnt + 1;
      if (m_cnt == MAXCNT) m_sat = 1'b1;
    end else if (m_sat) begin
      mn = -1;
      for (int k = 0; k < ENTNUM; k++)
        if (pre[k] && (mn < 0 || m_age[k] < mn)) mn = m_age[k];
`ifdef AGE_REBASE_EN
      if (mn < 0) begin
        m_cnt = 0;
        m_sat = 1'b0;
      end else if (mn > 0) begin
        for (int k = 0; k < ENTNUM; k++) if (pre[k]) m_age[k] = m_age[k] - mn;
        m_cnt = m_cnt - mn;
        m_sat = 1'b0;
      end
`else
      if (mn < 0) begin
        m_cnt = 0;
        m_sat = 1'b0;
      end
`endif
    end
  endtask

  task automatic check_outputs(input bit fl);
    int e;
    e = model_lowest_free();
    check_eq("alloc_ready", 32'(alloc_ready_o), 32'(model_ready(fl)));
    check_eq("alloc_age", 32'(alloc_age_o), 32'(m_cnt));
    if (e >= 0) check_eq("alloc_entry", 32'(alloc_entry_o), 32'(e));
    check_eq("busy_vector", 32'(busy_vector_o), model_busy_vec());
    for (int k = 0; k < ENTNUM; k++)
      if (m_busy[k]) check_eq("entry_age", 32'(age_vector_o[k*VALLEN +: VALLEN]), 32'(m_age[k]));
  endtask

  task automatic cycle(input bit av, input bit fv, input int fe, input bit fl);
    logic [31:0] fe_v;
    fe_v          = 32'(fe);
    alloc_valid_i = av;
    free_valid_i  = fv;
    free_entry_i  = fe_v[ENTLEN-1:0];
    flush_i       = fl;
    @(negedge clk_i);
    check_outputs(fl);
    @(posedge clk_i);
    model_step(av, fv, fe, fl);
    #1;
  endtask

  task automatic check_reset_values();
    check_eq("rst_ready", 32'(alloc_ready_o), 32'd1);
    check_eq("rst_entry", 32'(alloc_entry_o), 32'd0);
    check_eq("rst_age", 32'(alloc_age_o), 32'd0);
    check_eq("rst_busy", 32'(busy_vector_o), 32'd0);
    check_eq("rst_agevec", 32'(age_vector_o), 32'd0);
  endtask

  initial begin
    rst_n_i       = 1'b0;
    flush_i       = 1'b0;
    alloc_valid_i = 1'b0;
    free_valid_i  = 1'b0;
    free_entry_i  = 2'd0;
    model_reset();
    #1;
    check_reset_values();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Fill, full stall, free+alloc collision, then drive the counter to saturation.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b1, 2, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);
    check_eq("regrant_age", 32'(m_age[2]), 32'd4);
    cycle(1'b0, 1'b1, 0, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b1, 2, 1'b0);
    cycle(1'b0, 1'b1, 1, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b1, 0, 1'b0);
    cycle(1'b1, 1'b1, 1, 1'b0);
    cycle(1'b1, 1'b1, 3, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 1'b0);

    // Saturate with an age-0 entry still busy, then release it.
    cycle(1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      cycle(1'b0, 1'b1, k, 1'b0);
      cycle(1'b1, 1'b0, 0, 1'b0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 1'b0);

    // Flush with alloc and free asserted.
    cycle(1'b1, 1'b1, 1, 1'b1);
    check_eq("flush_busy", 32'(busy_vector_o), 32'd0);
    check_eq("flush_age", 32'(alloc_age_o), 32'd0);

    // Reach saturation again, then reset asynchronously mid-cycle.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 3, 1'b0);
      cycle(1'b1, 1'b0, 0, 1'b0);
    end
    cycle(1'b1, 1'b0, 0, 1'b0);
    alloc_valid_i = 1'b0;
    free_valid_i  = 1'b0;
    flush_i       = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 5) < 2, int'($urandom % ENTNUM), ($urandom % 64) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
